// File: rtl/intra16_mode_decision_if.sv
// Handshake and pixel/result bundle between the extractor, the Intra16x16 mode decision
// and its consumer. The master drives a job; the slave reports the decision.
interface intra16_mode_decision_if #(
  parameter int SAD_W = 16
);
  logic                 start;
  logic [255:0][7:0]    mb;
  logic [15:0][7:0]     toppixels;
  logic [15:0][7:0]     leftpixels;
  logic                 busy;
  logic                 done;
  logic [1:0]           best_mode;
  logic [SAD_W-1:0]     best_sad;
  logic [7:0]           dc_value;

  modport master (
    output start, mb, toppixels, leftpixels,
    input  busy, done, best_mode, best_sad, dc_value
  );

  modport slave (
    input  start, mb, toppixels, leftpixels,
    output busy, done, best_mode, best_sad, dc_value
  );
endinterface

// File: rtl/intra16_mode_decision.sv
// Intra16x16 luma mode decision: SAD of vertical, horizontal and DC prediction,
// one macroblock row per clock, then pick the cheapest mode (ties to the lower index).
//
// state    | meaning
// S_IDLE   | waiting for start; job inputs captured on the accept edge
// S_ROWS   | accumulating the three SADs, one MB row per clock
// S_DECIDE | choose the best mode, register results, pulse done
module intra16_mode_decision #(
  parameter int MB_SIZE_L = 16,
  parameter int MB_SIZE_W = 16,
  parameter int SAD_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  intra16_mode_decision_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROWS   = 2'd1,
    S_DECIDE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [255:0][7:0] mb_q;
  logic [15:0][7:0]  top_q;
  logic [15:0][7:0]  left_q;
  logic [7:0]        dc_q;
  logic [3:0]        row_q;
  logic [SAD_W-1:0]  sad_v, sad_h, sad_d;

  logic              busy_q, done_q;
  logic [1:0]        best_mode_q;
  logic [SAD_W-1:0]  best_sad_q;
  logic [7:0]        dc_value_q;

  logic              accept;
  logic              row_last;
  logic [12:0]       edge_sum;
  logic [7:0]        dc_nxt;
  logic [11:0]       row_v, row_h, row_d;
  logic [7:0]        pix;
  logic [1:0]        mode_sel;
  logic [SAD_W-1:0]  sad_sel;

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign row_last = (row_q == 4'(MB_SIZE_L - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_ROWS;
        end
      end
      S_ROWS: begin
        if (row_last) state_nxt = S_DECIDE;
      end
      S_DECIDE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // DC predictor from the live neighbours; 32 x 255 + 16 still fits in 13 bits
  always_comb begin
    edge_sum = 13'd16;
    for (int i = 0; i < 16; i++) begin
      edge_sum = edge_sum + 13'(bus.toppixels[4'(i)]) + 13'(bus.leftpixels[4'(i)]);
    end
    dc_nxt = edge_sum[12:5];
  end

  always_comb begin
    row_v = '0;
    row_h = '0;
    row_d = '0;
    pix   = '0;
    for (int c = 0; c < MB_SIZE_W; c++) begin
      pix   = mb_q[{row_q, 4'(c)}];
      row_v = row_v + 12'(absdiff(pix, top_q[4'(c)]));
      row_h = row_h + 12'(absdiff(pix, left_q[row_q]));
      row_d = row_d + 12'(absdiff(pix, dc_q));
    end
  end

  always_comb begin
    mode_sel = 2'd2;
    sad_sel  = sad_d;
    if (sad_v <= sad_h && sad_v <= sad_d) begin
      mode_sel = 2'd0;
      sad_sel  = sad_v;
    end else if (sad_h <= sad_d) begin
      mode_sel = 2'd1;
      sad_sel  = sad_h;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mb_q        <= '0;
      top_q       <= '0;
      left_q      <= '0;
      dc_q        <= '0;
      row_q       <= '0;
      sad_v       <= '0;
      sad_h       <= '0;
      sad_d       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      best_mode_q <= '0;
      best_sad_q  <= '0;
      dc_value_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        mb_q   <= bus.mb;
        top_q  <= bus.toppixels;
        left_q <= bus.leftpixels;
        dc_q   <= dc_nxt;
        row_q  <= '0;
        sad_v  <= '0;
        sad_h  <= '0;
        sad_d  <= '0;
        busy_q <= 1'b1;
      end
      if (state == S_ROWS) begin
        sad_v <= sad_v + SAD_W'(row_v);
        sad_h <= sad_h + SAD_W'(row_h);
        sad_d <= sad_d + SAD_W'(row_d);
        row_q <= row_q + 4'd1;
      end
      if (state == S_DECIDE) begin
        best_mode_q <= mode_sel;
        best_sad_q  <= sad_sel;
        dc_value_q  <= dc_q;
        done_q      <= 1'b1;
        busy_q      <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.best_mode = best_mode_q;
  assign bus.best_sad  = best_sad_q;
  assign bus.dc_value  = dc_value_q;

endmodule

// File: tb/tb_intra16_mode_decision.sv
// Directed bench for intra16_mode_decision: stimulus pushes hand-computed results into a
// scoreboard queue, and a monitor pops and compares on every done pulse.
module tb_intra16_mode_decision;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  intra16_mode_decision_if #(.SAD_W(16)) bus ();

  intra16_mode_decision #(
    .MB_SIZE_L (16),
    .MB_SIZE_W (16),
    .SAD_W     (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int mode;
    int sad;
    int dc;
    int cyc;
    int id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("t%0d_mode", mon_e.id), int'(bus.best_mode), mon_e.mode);
        check($sformatf("t%0d_sad", mon_e.id), int'(bus.best_sad), mon_e.sad);
        check($sformatf("t%0d_dc", mon_e.id), int'(bus.dc_value), mon_e.dc);
        check($sformatf("t%0d_latency", mon_e.id), cyc, mon_e.cyc);
      end
    end
  end

  task automatic set_uniform(input int m, input int t, input int l);
    for (int i = 0; i < 256; i++) bus.mb[8'(i)] = 8'(m);
    for (int i = 0; i < 16; i++) begin
      bus.toppixels[4'(i)]  = 8'(t);
      bus.leftpixels[4'(i)] = 8'(l);
    end
  endtask

  task automatic set_ramp();
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) bus.mb[8'(r * 16 + c)] = 8'(10 * r);
      bus.leftpixels[4'(r)] = 8'(10 * r);
      bus.toppixels[4'(r)]  = 8'd200;
    end
  endtask

  task automatic push(input int mode, input int sad, input int dc, input int c, input int id);
    exp_t e;
    e.mode = mode; e.sad = sad; e.dc = dc; e.cyc = c; e.id = id;
    exp_q.push_back(e);
  endtask

  // Returns the cycle index of the accept edge; inputs are scrambled right after it.
  task automatic start_job(output int n);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    bus.start = 1'b0;
    set_uniform(1, 2, 3);
  endtask

  task automatic wait_empty(input int id);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL t%0d_timeout: got %0d pending results, expected 0", id, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_uniform(input int id, input int m, input int t, input int l,
                             input int emode, input int esad, input int edc);
    int n;
    set_uniform(m, t, l);
    start_job(n);
    push(emode, esad, edc, n + 17, id);
    check($sformatf("t%0d_busy", id), int'(bus.busy), 1);
    wait_empty(id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b0;
    set_uniform(0, 0, 0);
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_mode", int'(bus.best_mode), 0);
    check("reset_sad", int'(bus.best_sad), 0);
    check("reset_dc", int'(bus.dc_value), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_uniform(1, 100, 100, 50, 0, 0, 75);

    set_ramp();
    start_job(n);
    push(1, 0, 138, n + 17, 2);
    wait_empty(2);

    run_uniform(4, 10, 10, 10, 0, 0, 10);
    run_uniform(5, 255, 0, 0, 0, 65280, 0);
    run_uniform(3, 128, 0, 255, 2, 0, 128);
    run_uniform(9, 90, 100, 85, 2, 768, 93);
    run_uniform(10, 90, 100, 94, 1, 1024, 97);

    // start held high across done: second job is accepted on the edge after DECIDE
    set_uniform(100, 100, 50);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    set_ramp();
    push(0, 0, 75, n + 17, 7);
    push(1, 0, 138, n + 35, 8);
    repeat (18) @(posedge clk);
    #1;
    check("b2b_reaccept_busy", int'(bus.busy), 1);
    bus.start = 1'b0;
    wait_empty(8);

    // start during a job is ignored; reset mid-job aborts with no done
    set_uniform(100, 100, 50);
    start_job(n);
    while (cyc < n + 4) @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("t6_busy_after_ignored_start", int'(bus.busy), 1);
    while (cyc < n + 8) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_abort_busy", int'(bus.busy), 0);
    check("t6_abort_done", int'(bus.done), 0);
    check("t6_abort_mode", int'(bus.best_mode), 0);
    check("t6_abort_sad", int'(bus.best_sad), 0);
    check("t6_abort_dc", int'(bus.dc_value), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_idle_after_abort", int'(bus.busy), 0);
    run_uniform(6, 100, 100, 50, 0, 0, 75);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
